// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the RV32I pipeline.
//   DPW          - datapath width
//   alu_op_t     - ALU operation encoding (ALU_ADD is the all-zero code)
//   idex_ctrl_t  - control bundle carried from decode into execute
//   idex_state_t - occupancy of the ID/EX holding stage
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

  typedef struct packed {
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    alu_op_t    alu_ctrl;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } idex_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready holding stage with an optional skid entry.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake, in_data payload
//   flush                - turn every held entry into a bubble
//   out_valid/out_ready  - downstream handshake, out_data payload
//
// state | meaning
// EMPTY | nothing held, out_valid low
// ONE   | main entry holds a beat
// TWO   | main and skid both hold beats, in_ready low
//
// Bubbles carry all-zero data so a downstream decoder sees a harmless nop.
module pipe_skid_buf
  import rv32i_pkg::*;
#(
  parameter int W       = 8,
  parameter int SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  idex_state_t  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         accept;
  logic         drain;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  // Without the skid entry the stage can only accept when the held beat leaves.
  assign in_ready  = (SKID_EN != 0) ? ready_q : (out_ready || !out_valid);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && (drain || SKID_EN == 0)) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q  <= in_data;
            state   <= TWO;
            ready_q <= 1'b0;
          end else if (drain) begin
            main_q <= '0;
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with writeback forwarding.
//   clk, rst                      - clock, synchronous active-high reset
//   valid_d/ready_d               - decode-side handshake
//   ctrl_d, rs*_d, rd_d, rd*_d,
//   imm_d, pc_d                   - decoded beat
//   wb_we, wb_addr, wb_data       - writeback port snoop for forwarding
//   flush_e, ready_e              - execute-side kill and accept
//   valid_e, ctrl_e, rs*_e, rd_e,
//   srca_e, rd2_e, imm_e, pc_e    - beat presented to execute
module idex_pipe_reg
  import rv32i_pkg::*;
#(
  parameter int ADW       = 5,
  parameter int SKID_EN   = 1,
  parameter int BYPASS_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_d,
  output logic           ready_d,
  input  idex_ctrl_t     ctrl_d,
  input  logic [ADW-1:0] rs1_d,
  input  logic [ADW-1:0] rs2_d,
  input  logic [ADW-1:0] rd_d,
  input  logic [DPW-1:0] rd1_d,
  input  logic [DPW-1:0] rd2_d,
  input  logic [DPW-1:0] imm_d,
  input  logic [DPW-1:0] pc_d,
  input  logic           wb_we,
  input  logic [ADW-1:0] wb_addr,
  input  logic [DPW-1:0] wb_data,
  input  logic           flush_e,
  input  logic           ready_e,
  output logic           valid_e,
  output idex_ctrl_t     ctrl_e,
  output logic [ADW-1:0] rs1_e,
  output logic [ADW-1:0] rs2_e,
  output logic [ADW-1:0] rd_e,
  output logic [DPW-1:0] srca_e,
  output logic [DPW-1:0] rd2_e,
  output logic [DPW-1:0] imm_e,
  output logic [DPW-1:0] pc_e
);

  localparam int W = $bits(idex_ctrl_t) + 3 * ADW + 4 * DPW;

  logic           fwd1;
  logic           fwd2;
  logic [DPW-1:0] srca_d;
  logic [DPW-1:0] rd2_fwd_d;
  logic [W-1:0]   in_data;
  logic [W-1:0]   out_data;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign fwd1 = (BYPASS_EN != 0) && wb_we && (wb_addr == rs1_d) && (rs1_d != '0);
  assign fwd2 = (BYPASS_EN != 0) && wb_we && (wb_addr == rs2_d) && (rs2_d != '0);

  assign srca_d    = fwd1 ? wb_data : rd1_d;
  assign rd2_fwd_d = fwd2 ? wb_data : rd2_d;

  assign in_data = {ctrl_d, rs1_d, rs2_d, rd_d, srca_d, rd2_fwd_d, imm_d, pc_d};
  assign {ctrl_e, rs1_e, rs2_e, rd_e, srca_e, rd2_e, imm_e, pc_e} = out_data;

  pipe_skid_buf #(
    .W       (W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (valid_d),
    .in_ready  (ready_d),
    .in_data   (in_data),
    .flush     (flush_e),
    .out_ready (ready_e),
    .out_valid (valid_e),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_idex_pipe_reg.sv
module tb_idex_pipe_reg;
  import rv32i_pkg::*;

  localparam idex_ctrl_t CTRL_T = '{resultsrc: 2'b01, memwrite: 1'b1, alusrc: 1'b1,
                                    regwrite: 1'b1, alu_ctrl: ALU_SUB};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (skid enabled, bypass enabled)
  logic        valid_d, ready_d, wb_we, flush_e, ready_e, valid_e;
  idex_ctrl_t  ctrl_d, ctrl_e;
  logic [4:0]  rs1_d, rs2_d, rd_d, wb_addr, rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d, wb_data, srca_e, rd2_e, imm_e, pc_e;

  idex_pipe_reg dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d), .ctrl_d(ctrl_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_d(imm_d), .pc_d(pc_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush_e(flush_e), .ready_e(ready_e), .valid_e(valid_e), .ctrl_e(ctrl_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .srca_e(srca_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc_e(pc_e)
  );

  // second DUT: single register, no skid
  logic        n_valid_d, n_ready_d, n_ready_e, n_valid_e;
  idex_ctrl_t  n_ctrl_e;
  logic [4:0]  n_rs1_e, n_rs2_e, n_rd_e;
  logic [31:0] n_pc_d, n_srca_e, n_rd2_e, n_imm_e, n_pc_e;

  idex_pipe_reg #(.ADW(5), .SKID_EN(0), .BYPASS_EN(1)) dut_ns (
    .clk(clk), .rst(rst), .valid_d(n_valid_d), .ready_d(n_ready_d), .ctrl_d(CTRL_T),
    .rs1_d(5'd1), .rs2_d(5'd2), .rd_d(5'd3), .rd1_d(32'h11), .rd2_d(32'h22),
    .imm_d(32'h33), .pc_d(n_pc_d), .wb_we(1'b0), .wb_addr(5'd0), .wb_data(32'h0),
    .flush_e(1'b0), .ready_e(n_ready_e), .valid_e(n_valid_e), .ctrl_e(n_ctrl_e),
    .rs1_e(n_rs1_e), .rs2_e(n_rs2_e), .rd_e(n_rd_e), .srca_e(n_srca_e), .rd2_e(n_rd2_e),
    .imm_e(n_imm_e), .pc_e(n_pc_e)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [31:0] rd1;
    logic [4:0]  rs2;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] esrca;
    logic [31:0] erd2;
    logic        erdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic re,
                              input logic fl, input logic ev, input logic [31:0] epc,
                              input logic erdy);
    vec_t t;
    t.v = v; t.pc = pc; t.re = re; t.fl = fl; t.ev = ev; t.epc = epc; t.erdy = erdy;
    t.rs1 = '0; t.rd1 = '0; t.rs2 = '0; t.rd2 = '0;
    t.we = 1'b0; t.wa = '0; t.wd = '0; t.esrca = '0; t.erd2 = '0;
    return t;
  endfunction

  vec_t tv[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // idle inputs
    rst = 1'b1; valid_d = 1'b1; ctrl_d = CTRL_T; rs1_d = '0; rs2_d = '0; rd_d = 5'd4;
    rd1_d = '0; rd2_d = '0; imm_d = 32'h0; pc_d = 32'h99; wb_we = 1'b0; wb_addr = '0;
    wb_data = '0; flush_e = 1'b0; ready_e = 1'b1;
    n_valid_d = 1'b0; n_pc_d = '0; n_ready_e = 1'b1;

    // reset held two cycles with a beat offered
    tick(); tick();
    chk("rst_valid_e", {31'b0, valid_e}, 32'd0);
    chk("rst_ready_d", {31'b0, ready_d}, 32'd1);
    chk("rst_ctrl_e", {23'b0, ctrl_e}, 32'd0);
    chk("rst_alu_ctrl", {28'b0, ctrl_e.alu_ctrl}, {28'b0, ALU_ADD});
    chk("rst_pc_e", pc_e, 32'd0);
    rst = 1'b0;

    //          v     pc      re    fl    ev    epc     erdy
    tv[0]  = mk(1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1);
    tv[1]  = mk(1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1);
    tv[2]  = mk(1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1);
    tv[3]  = mk(1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1);
    tv[4]  = mk(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1);
    // stall: 0x10 held, 0x14 into skid, 0x18 refused, then release in order
    tv[5]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    tv[6]  = mk(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    tv[7]  = mk(1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    tv[8]  = mk(1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1);
    tv[9]  = mk(1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1);
    tv[10] = mk(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1);
    // flush from TWO with 0x20 offered
    tv[11] = mk(1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1);
    tv[12] = mk(1'b1, 32'h34, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    tv[13] = mk(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1);
    tv[14] = mk(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1);
    // bypass
    tv[15] = mk(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
    tv[15].rs1 = 5'd5; tv[15].rd1 = 32'h1; tv[15].rs2 = 5'd5; tv[15].rd2 = 32'h2;
    tv[15].we = 1'b1; tv[15].wa = 5'd5; tv[15].wd = 32'hDEADBEEF;
    tv[15].esrca = 32'hDEADBEEF; tv[15].erd2 = 32'hDEADBEEF;
    tv[16] = mk(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1);
    tv[16].rs1 = 5'd0; tv[16].rd1 = 32'h1; tv[16].rs2 = 5'd0; tv[16].rd2 = 32'h2;
    tv[16].we = 1'b1; tv[16].wa = 5'd0; tv[16].wd = 32'hDEADBEEF;
    tv[16].esrca = 32'h1; tv[16].erd2 = 32'h2;
    tv[17] = mk(1'b1, 32'h48, 1'b1, 1'b0, 1'b1, 32'h48, 1'b1);
    tv[17].rs1 = 5'd7; tv[17].rd1 = 32'h2; tv[17].rs2 = 5'd6; tv[17].rd2 = 32'h3;
    tv[17].we = 1'b0; tv[17].wa = 5'd7; tv[17].wd = 32'hCAFEF00D;
    tv[17].esrca = 32'h2; tv[17].erd2 = 32'h3;
    tv[18] = mk(1'b1, 32'h4C, 1'b1, 1'b0, 1'b1, 32'h4C, 1'b1);
    tv[18].rs1 = 5'd3; tv[18].rd1 = 32'h9; tv[18].rs2 = 5'd4; tv[18].rd2 = 32'h8;
    tv[18].we = 1'b1; tv[18].wa = 5'd4; tv[18].wd = 32'h12345678;
    tv[18].esrca = 32'h9; tv[18].erd2 = 32'h12345678;
    tv[19] = mk(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1);

    for (int i = 0; i < 20; i++) begin
      valid_d = tv[i].v; pc_d = tv[i].pc; imm_d = tv[i].pc ^ 32'h0000FFFF;
      ctrl_d  = tv[i].v ? CTRL_T : '0;
      rs1_d = tv[i].rs1; rd1_d = tv[i].rd1; rs2_d = tv[i].rs2; rd2_d = tv[i].rd2;
      wb_we = tv[i].we; wb_addr = tv[i].wa; wb_data = tv[i].wd;
      ready_e = tv[i].re; flush_e = tv[i].fl;
      tick();
      chk($sformatf("v%0d_valid_e", i), {31'b0, valid_e}, {31'b0, tv[i].ev});
      chk($sformatf("v%0d_pc_e", i), pc_e, tv[i].epc);
      chk($sformatf("v%0d_imm_e", i), imm_e, tv[i].ev ? (tv[i].epc ^ 32'h0000FFFF) : 32'h0);
      chk($sformatf("v%0d_ctrl_e", i), {23'b0, ctrl_e}, tv[i].ev ? {23'b0, CTRL_T} : 32'h0);
      chk($sformatf("v%0d_srca_e", i), srca_e, tv[i].esrca);
      chk($sformatf("v%0d_rd2_e", i), rd2_e, tv[i].erd2);
      chk($sformatf("v%0d_ready_d", i), {31'b0, ready_d}, {31'b0, tv[i].erdy});
    end
    flush_e = 1'b0; valid_d = 1'b0;

    // no-skid instance: ready_e toggles, 8 beats must arrive in order
    begin
      logic        m_valid;
      logic [31:0] m_pc;
      logic        exp_rdy;
      int          sent;
      int          got;
      int          cyc;
      m_valid = 1'b0; m_pc = '0; sent = 0; got = 0; cyc = 0;
      while (got < 8 && cyc < 60) begin
        n_ready_e = (cyc % 2 == 0);
        n_valid_d = (sent < 8);
        n_pc_d    = 32'h100 + 32'(sent) * 4;
        #1;
        exp_rdy = n_ready_e || !m_valid;
        chk($sformatf("ns%0d_ready_d", cyc), {31'b0, n_ready_d}, {31'b0, exp_rdy});
        if (m_valid && n_ready_e) begin
          chk($sformatf("ns_order%0d", got), n_pc_e, 32'h100 + 32'(got) * 4);
          got++;
        end
        if (n_valid_d && exp_rdy) begin
          m_pc = n_pc_d; m_valid = 1'b1; sent++;
        end else if (m_valid && n_ready_e) begin
          m_valid = 1'b0; m_pc = '0;
        end
        @(posedge clk); #1;
        chk($sformatf("ns%0d_valid_e", cyc), {31'b0, n_valid_e}, {31'b0, m_valid});
        chk($sformatf("ns%0d_pc_e", cyc), n_pc_e, m_pc);
        cyc++;
      end
      chk("ns_beats_delivered", 32'(got), 32'd8);
      n_valid_d = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 Parameters SHALL be: ADW, default 5, register-address width; SKID_EN, default 1, 1 = two-entry skid buffer, 0 = single register; BYPASS_EN, default 1, enables writeback-to-decode forwarding.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be: valid_d  in  1  decode beat valid; ready_d  out  1  stage can accept a beat.
REQ-004 Ports SHALL be: ctrl_d  in  idex_ctrl_t  resultsrc/memwrite/alusrc/regwrite/alu_ctrl from control unit.
REQ-005 Ports SHALL be: rs1_d, rs2_d, rd_d  in  ADW  source/destination addresses; rd1_d, rd2_d, imm_d, pc_d  in  DPW  operands, extended immediate, PC.
REQ-006 Ports SHALL be: wb_we  in  1; wb_addr  in  ADW; wb_data  in  DPW  writeback-port snoop.
REQ-007 Ports SHALL be: flush_e  in  1  kill all held beats; ready_e  in  1  execute accepts.
REQ-008 Ports SHALL be: valid_e  out  1; ctrl_e  out  idex_ctrl_t; rs1_e, rs2_e, rd_e  out  ADW; srca_e, rd2_e, imm_e, pc_e  out  DPW.

Function
REQ-009 A beat SHALL transfer in on valid_d && ready_d, and out on valid_e && ready_e.
REQ-010 Latency SHALL be one cycle: a beat accepted at edge N SHALL appear on outputs after edge N when the stage was empty.
REQ-011 With SKID_EN=1, states SHALL be EMPTY, ONE (main held), TWO (main+skid held); ready_d SHALL be 1 in EMPTY/ONE, 0 in TWO, driven from a register only.
REQ-012 Transitions SHALL be: EMPTY-accept->ONE; ONE-accept-only->TWO; ONE-drain-only->EMPTY; ONE accept+drain->ONE (new beat into main); TWO-drain->ONE (skid moves to main); all others hold.
REQ-013 With SKID_EN=0, ready_d SHALL equal ready_e || !valid_e and only the main entry SHALL exist.
REQ-014 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush.
REQ-015 With BYPASS_EN=1, on accept, if wb_we && wb_addr==rs1_d && rs1_d!=0, the captured srca SHALL be wb_data instead of rd1_d; same rule for rs2_d/rd2_d.
REQ-016 Writes to address 0 SHALL never be forwarded.
REQ-017 When flush_e=1 at an edge, both entries SHALL become bubbles (valid 0, ctrl all 0, alu_ctrl ALU_ADD, data 0), state SHALL go EMPTY, and any beat offered that cycle SHALL be discarded.
REQ-018 Flush SHALL take priority over accept, drain and stall in the same cycle.
REQ-019 Held entries SHALL stay bit-stable while valid_e && !ready_e.
REQ-020 ctrl_e.regwrite and ctrl_e.memwrite SHALL be 0 whenever valid_e is 0.

Reset
REQ-021 On rst=1 at a clock edge, state SHALL be EMPTY, valid_e 0, ready_d 1, ctrl_e all 0 with alu_ctrl ALU_ADD, all data/address outputs 0, skid entry cleared.
REQ-022 rst SHALL dominate flush_e and all handshakes; a beat in flight at reset SHALL be lost.

Structure
REQ-023 idex_ctrl_t (packed struct) and idex_state_t (EMPTY/ONE/TWO) SHALL reside in rv32i_pkg alongside DPW and alu_op_t.
REQ-024 A generic width-parametrised sub-module pipe_skid_buf SHALL implement REQ-011..014 and REQ-017; idex_pipe_reg SHALL add bypass and packing.

Verification
REQ-025 Reset: assert rst 2 cycles with valid_d=1 -> valid_e=0, ready_d=1, ctrl_e=0, alu_ctrl=ALU_ADD.
REQ-026 Back-to-back: 4 beats pc_d=0x0,0x4,0x8,0xC, ready_e=1 -> pc_e 0x0..0xC on consecutive cycles, no bubble.
REQ-027 Stall: ready_e=0 after beat pc 0x10, offer 0x14, 0x18 -> ready_d falls after 0x14 accepted; release -> 0x10, 0x14, 0x18 in order.
REQ-028 Flush: state TWO, flush_e=1 with valid_d=1 pc 0x20 -> next cycle valid_e=0, regwrite_e=0, ready_d=1; 0x20 never emerges.
REQ-029 Bypass: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, rs1_d=5, rd1_d=0x1 -> srca_e=0xDEADBEEF; repeat with addr 0 -> srca_e=rd1_d.
REQ-030 SKID_EN=0: ready_e toggling 1/0 each cycle over 8 beats -> ready_d tracks REQ-013, all 8 beats delivered in order.
